// File: rtl/cpu_bus_pkg.sv
// Shared constants for agents on the 4-bit multiplexed instruction bus.
// Every agent counts the same 8-subcycle frame from a common reset.
package cpu_bus_pkg;

    localparam int CYCLE_W  = 3;
    localparam int PC_WIDTH = 12;

    // Subcycles: three address nibbles, two opcode nibbles, three execute slots.
    localparam logic [CYCLE_W-1:0] A1 = 3'd0;
    localparam logic [CYCLE_W-1:0] A2 = 3'd1;
    localparam logic [CYCLE_W-1:0] A3 = 3'd2;
    localparam logic [CYCLE_W-1:0] M1 = 3'd3;
    localparam logic [CYCLE_W-1:0] M2 = 3'd4;
    localparam logic [CYCLE_W-1:0] X1 = 3'd5;
    localparam logic [CYCLE_W-1:0] X2 = 3'd6;
    localparam logic [CYCLE_W-1:0] X3 = 3'd7;

endpackage

// File: rtl/bus_cycle_counter.sv
// Free-running subcycle counter and frame marker, shared by all bus agents.
// Alignment between agents relies purely on a common synchronous reset.
module bus_cycle_counter
    import cpu_bus_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    output logic [CYCLE_W-1:0] cycle,
    output logic               sync
);

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle <= A1;
        end else begin
            cycle <= cycle + 1'b1;
        end
    end

    assign sync = (cycle == X3);

endmodule

// File: rtl/fetch_unit.sv
// Bus initiator: drives the PC nibbles, samples the opcode nibbles from the ROM,
// and advances the PC (or loads a jump target) at each frame boundary.
module fetch_unit #(
    parameter int                    PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = 12'h000
) (
    input  logic                clock,
    input  logic                reset,
    inout  wire  [3:0]          data,
    output logic                sync,
    input  logic                jump_valid,
    input  logic [PC_WIDTH-1:0] jump_addr,
    input  logic                halt,
    output logic [7:0]          instr,
    output logic [PC_WIDTH-1:0] instr_addr,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc
);

    import cpu_bus_pkg::*;

    logic [CYCLE_W-1:0]  cycle;
    logic [3:0]          opr_q;
    logic [3:0]          bus_nib;
    logic                bus_drive;
    logic                jump_pending;
    logic [PC_WIDTH-1:0] jump_q;

    bus_cycle_counter u_cycle (
        .clock (clock),
        .reset (reset),
        .cycle (cycle),
        .sync  (sync)
    );

    // The bus is only ours in A1..A3; the ROM owns M1/M2.
    always_comb begin
        bus_drive = 1'b1;
        bus_nib   = pc[3:0];
        case (cycle)
            A1:      bus_nib = pc[3:0];
            A2:      bus_nib = pc[7:4];
            A3:      bus_nib = pc[11:8];
            default: begin
                bus_drive = 1'b0;
                bus_nib   = 4'h0;
            end
        endcase
    end

    assign data = bus_drive ? bus_nib : 4'bz;

    always_ff @(posedge clock) begin
        if (reset) begin
            opr_q       <= 4'h0;
            instr       <= 8'h00;
            instr_addr  <= '0;
            instr_valid <= 1'b0;
        end else begin
            instr_valid <= (cycle == M2);
            if (cycle == M1) begin
                opr_q <= data;
            end
            if (cycle == M2) begin
                instr      <= {opr_q, data};
                instr_addr <= pc;
            end
        end
    end

    // A jump arriving on the boundary clock itself takes effect immediately;
    // the later assignments below override the latch update on that clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc           <= RESET_PC;
            jump_pending <= 1'b0;
            jump_q       <= '0;
        end else begin
            if (jump_valid) begin
                jump_pending <= 1'b1;
                jump_q       <= jump_addr;
            end
            if (cycle == X3 && !halt) begin
                if (jump_valid) begin
                    pc           <= jump_addr;
                    jump_pending <= 1'b0;
                end else if (jump_pending) begin
                    pc           <= jump_q;
                    jump_pending <= 1'b0;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

endmodule
